// File: rtl/pc_select_if.sv
// pc_select_if: groups the fetch-side PC control signals of the Y86-64 pipeline.
// master: the pipeline side driving fetch/M/W information and the stall.
// slave:  the pc_select block producing f_pc, F_predPC and the ret hazard flags.
interface pc_select_if;
  logic [3:0]  f_icode;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic        F_stall;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic [63:0] f_pc;
  logic [63:0] F_predPC;
  logic        ret_stall;
  logic        ras_mispred;

  modport master (
    output f_icode, f_valC, f_valP, F_stall,
    output M_icode, M_Cnd, M_valA, W_icode, W_valM,
    input  f_pc, F_predPC, ret_stall, ras_mispred
  );

  modport slave (
    input  f_icode, f_valC, f_valP, F_stall,
    input  M_icode, M_Cnd, M_valA, W_icode, W_valM,
    output f_pc, F_predPC, ret_stall, ras_mispred
  );
endinterface

// File: rtl/pc_select.sv
// pc_select: Y86-64 fetch-side PC selection and next-PC prediction.
// Holds F_predPC, picks the PC driven into fetch (mispredict recovery, ret
// resolution or prediction) and tracks in-flight rets for the hazard unit.
// Optional feature macro: PC_SELECT_RAS_EN builds a circular return-address
// stack plus an outstanding-ret queue so predicted rets need not stall.
module pc_select #(
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned RQ_DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst,
  pc_select_if.slave    bus
);

  // Ring pointers rely on natural wrap-around, so depths must be powers of two.
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0 ||
      RQ_DEPTH < 2 || (RQ_DEPTH & (RQ_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("pc_select: RAS_DEPTH and RQ_DEPTH must be powers of two >= 2");
  end

  logic        mispred;
  logic        wret;
  logic        redirect;
  logic        pred_load;
  logic [63:0] pred_nxt;
  logic [63:0] pred_pc_p0;

  assign mispred = (bus.M_icode == 4'h7) && !bus.M_Cnd;
  assign wret    = (bus.W_icode == 4'h9);

  assign bus.f_pc     = mispred  ? bus.M_valA :
                        redirect ? bus.W_valM : pred_pc_p0;
  assign bus.F_predPC = pred_pc_p0;

  // F pipeline register: predicted PC of the next instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pred_pc_p0 <= '0;
    else if (pred_load) pred_pc_p0 <= pred_nxt;
  end

`ifdef PC_SELECT_RAS_EN
  localparam int RP_W = $clog2(RAS_DEPTH);
  localparam int RC_W = RP_W + 1;
  localparam int QP_W = $clog2(RQ_DEPTH);
  localparam int QC_W = QP_W + 1;
  localparam logic [RP_W-1:0] RP_ONE   = RP_W'(1);
  localparam logic [QP_W-1:0] QP_ONE   = QP_W'(1);
  localparam logic [RC_W-1:0] RAS_FULL = RC_W'(RAS_DEPTH);
  localparam logic [QC_W-1:0] RQ_FULL  = QC_W'(RQ_DEPTH);

  logic [63:0]     ras_mem [RAS_DEPTH];
  logic [RP_W-1:0] ras_ptr, ras_ptr_b, ras_ptr_n;
  logic [RC_W-1:0] ras_cnt, ras_cnt_b, ras_cnt_n;
  logic            ras_avail;
  logic [63:0]     ras_top;

  logic [63:0]     rq_tgt [RQ_DEPTH];
  logic            rq_vld [RQ_DEPTH];
  logic [QP_W-1:0] rq_head, rq_head_n, rq_tail, rq_tail_b, rq_tail_n;
  logic [QC_W-1:0] rq_cnt, rq_cnt_n, inv_cnt, inv_n;

  logic deq, head_vld, head_hit, ras_miss, flush;
  logic rq_full, ret_block, fetch_call, fetch_ret, retire_inv;

  // Retire side: the ret in W dequeues the oldest outstanding prediction.
  assign deq        = wret && (rq_cnt != '0);
  assign head_vld   = rq_vld[rq_head];
  assign head_hit   = head_vld && (rq_tgt[rq_head] == bus.W_valM);
  assign ras_miss   = deq && head_vld && !head_hit;
  assign retire_inv = deq && !head_vld;
  assign redirect   = wret && !(deq && head_hit);
  assign flush      = mispred || ras_miss;

  // A flush empties everything first; the instruction fetched this cycle is
  // on the corrected path and is applied on top of the cleared state.
  assign ras_ptr_b  = flush ? '0 : ras_ptr;
  assign ras_cnt_b  = flush ? '0 : ras_cnt;
  assign ras_avail  = (ras_cnt_b != '0);
  assign ras_top    = ras_mem[ras_ptr_b - RP_ONE];

  assign rq_full    = (rq_cnt == RQ_FULL);
  assign ret_block  = (bus.f_icode == 4'h9) && rq_full && !flush;
  assign fetch_call = (bus.f_icode == 4'h8) && !bus.F_stall;
  assign fetch_ret  = (bus.f_icode == 4'h9) && !bus.F_stall && !ret_block;

  assign rq_head_n  = flush ? '0 : (deq ? rq_head + QP_ONE : rq_head);
  assign rq_tail_b  = flush ? '0 : rq_tail;
  assign rq_tail_n  = fetch_ret ? rq_tail_b + QP_ONE : rq_tail_b;
  assign rq_cnt_n   = (flush ? '0 : rq_cnt - QC_W'(deq)) + QC_W'(fetch_ret);
  assign inv_n      = (flush ? '0 : inv_cnt - QC_W'(retire_inv)) +
                      QC_W'(fetch_ret && !ras_avail);

  assign ras_ptr_n  = fetch_call               ? ras_ptr_b + RP_ONE :
                      (fetch_ret && ras_avail) ? ras_ptr_b - RP_ONE : ras_ptr_b;
  assign ras_cnt_n  = fetch_call ? ((ras_cnt_b == RAS_FULL) ? ras_cnt_b : ras_cnt_b + RC_W'(1)) :
                      (fetch_ret && ras_avail) ? ras_cnt_b - RC_W'(1) : ras_cnt_b;

  assign pred_load       = !bus.F_stall && !ret_block;
  assign bus.ret_stall   = (inv_cnt > QC_W'(retire_inv)) || ret_block;
  assign bus.ras_mispred = ras_miss;

  // Next-PC prediction: jumps and calls take valC, predicted rets the RAS top.
  always_comb begin
    pred_nxt = bus.f_valP;
    case (bus.f_icode)
      4'h7, 4'h8: pred_nxt = bus.f_valC;
      4'h9:       if (ras_avail) pred_nxt = ras_top;
      default:    pred_nxt = bus.f_valP;
    endcase
  end

  // RAS and ret-queue control state; a stall freezes all of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      rq_head <= '0;
      rq_tail <= '0;
      rq_cnt  <= '0;
      inv_cnt <= '0;
    end else if (!bus.F_stall) begin
      ras_ptr <= ras_ptr_n;
      ras_cnt <= ras_cnt_n;
      rq_head <= rq_head_n;
      rq_tail <= rq_tail_n;
      rq_cnt  <= rq_cnt_n;
      inv_cnt <= inv_n;
    end
  end

  // Storage: pushed return addresses and the prediction made for each ret.
  always_ff @(posedge clk) begin
    if (fetch_call) ras_mem[ras_ptr_b] <= bus.f_valP;
    if (fetch_ret) begin
      rq_tgt[rq_tail_b] <= ras_top;
      rq_vld[rq_tail_b] <= ras_avail;
    end
  end
`else
  logic [2:0] inflight;

  // Classic PIPE: every ret redirects in W and stalls fetch until then.
  assign redirect        = wret;
  assign pred_load       = !bus.F_stall;
  assign bus.ret_stall   = (inflight > {2'b00, wret});
  assign bus.ras_mispred = 1'b0;

  // Next-PC prediction: jumps and calls take valC, everything else valP.
  always_comb begin
    pred_nxt = bus.f_valP;
    if (bus.f_icode == 4'h7 || bus.f_icode == 4'h8) pred_nxt = bus.f_valC;
  end

  // Count of rets between fetch and write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (!bus.F_stall) begin
      case ({bus.f_icode == 4'h9, wret})
        2'b10:   if (inflight != 3'h7) inflight <= inflight + 3'h1;
        2'b01:   if (inflight != 3'h0) inflight <= inflight - 3'h1;
        default: inflight <= inflight;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_pc_select.sv
// tb_pc_select: directed bench for pc_select. The driver applies one input
// vector per cycle and queues the hand-computed outputs for that cycle; an
// independent monitor pops and compares on the falling clock edge.
module tb_pc_select;
  logic clk = 1'b0;
  logic rst;

  pc_select_if bus ();

  pc_select #(.RAS_DEPTH(8), .RQ_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic [63:0] pred;
    logic        rs;
    logic        rm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void check(string nm, string fld, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s %s: got %h, want %h", nm, fld, got, want);
    end
  endfunction

  // Monitor: compare DUT outputs against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(e.name, "f_pc",        bus.f_pc,                 e.pc);
      check(e.name, "F_predPC",    bus.F_predPC,             e.pred);
      check(e.name, "ret_stall",   64'(bus.ret_stall),       64'(e.rs));
      check(e.name, "ras_mispred", 64'(bus.ras_mispred),     64'(e.rm));
    end
  end

  task automatic mw(input logic [3:0] mi, input logic mc, input logic [63:0] ma,
                    input logic [3:0] wi, input logic [63:0] wm);
    bus.M_icode = mi;
    bus.M_Cnd   = mc;
    bus.M_valA  = ma;
    bus.W_icode = wi;
    bus.W_valM  = wm;
  endtask

  task automatic step(input string nm, input logic [3:0] ic, input logic [63:0] vc,
                      input logic [63:0] vp, input logic st,
                      input logic [63:0] pc, input logic [63:0] pred,
                      input logic rs, input logic rm);
    exp_t e;
    bus.f_icode = ic;
    bus.f_valC  = vc;
    bus.f_valP  = vp;
    bus.F_stall = st;
    e.name = nm; e.pc = pc; e.pred = pred; e.rs = rs; e.rm = rm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    mw(4'h0, 1'b0, 64'h0, 4'h0, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] prev;
    rst = 1'b1;
    mw(4'h0, 1'b0, 64'h0, 4'h0, 64'h0);
    bus.f_icode = 4'h0; bus.f_valC = 64'h0; bus.f_valP = 64'h0; bus.F_stall = 1'b0;
    @(posedge clk);
    #1;
    step("reset", 4'h0, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step("seq0",  4'h6, 64'h0,  64'h2,  1'b0, 64'h0,  64'h0,  1'b0, 1'b0);
    step("jmp",   4'h7, 64'h40, 64'hB,  1'b0, 64'h2,  64'h2,  1'b0, 1'b0);
    mw(4'h7, 1'b0, 64'h15, 4'h0, 64'h0);
    step("mispr", 4'h6, 64'h0,  64'h17, 1'b0, 64'h15, 64'h40, 1'b0, 1'b0);
    mw(4'h7, 1'b1, 64'h99, 4'h0, 64'h0);
    step("taken", 4'h9, 64'h0,  64'h18, 1'b0, 64'h17, 64'h17, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("rstall", 4'h1, 64'h0, 64'h19, 1'b1, 64'h18, 64'h18, 1'b1, 1'b0);
    mw(4'h0, 1'b0, 64'h0, 4'h9, 64'h22);
    step("wret",  4'h6, 64'h0,  64'h24, 1'b0, 64'h22, 64'h18, 1'b0, 1'b0);
    step("stret", 4'h9, 64'h0,  64'h25, 1'b1, 64'h24, 64'h24, 1'b0, 1'b0);
    step("nocnt", 4'h1, 64'h0,  64'h26, 1'b0, 64'h24, 64'h24, 1'b0, 1'b0);
    step("ret2",  4'h9, 64'h0,  64'h27, 1'b0, 64'h26, 64'h26, 1'b0, 1'b0);
    step("rst2a", 4'h1, 64'h0,  64'h28, 1'b1, 64'h27, 64'h27, 1'b1, 1'b0);
    rst = 1'b1;
    step("midrst", 4'h1, 64'h0, 64'h28, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0);
    rst = 1'b0;
    mw(4'h7, 1'b0, 64'h60, 4'h9, 64'h70);
    step("prio",  4'h1, 64'h0,  64'h61, 1'b0, 64'h60, 64'h0,  1'b0, 1'b0);
    mw(4'h0, 1'b0, 64'h0, 4'h9, 64'h80);
    step("wret0", 4'h1, 64'h0,  64'h81, 1'b0, 64'h80, 64'h61, 1'b0, 1'b0);
`ifdef PC_SELECT_RAS_EN
    step("call1", 4'h8, 64'h100, 64'h8A, 1'b0, 64'h81,  64'h81,  1'b0, 1'b0);
    step("rhit",  4'h9, 64'h0,   64'h101, 1'b0, 64'h100, 64'h100, 1'b0, 1'b0);
    step("rtgt",  4'h1, 64'h0,   64'h8B, 1'b0, 64'h8A,  64'h8A,  1'b0, 1'b0);
    mw(4'h0, 1'b0, 64'h0, 4'h9, 64'h8A);
    step("whit",  4'h1, 64'h0,   64'h8C, 1'b0, 64'h8B,  64'h8B,  1'b0, 1'b0);
    step("call2", 4'h8, 64'h200, 64'h33, 1'b0, 64'h8C,  64'h8C,  1'b0, 1'b0);
    step("rpred", 4'h9, 64'h0,   64'h201, 1'b0, 64'h200, 64'h200, 1'b0, 1'b0);
    step("rtgt2", 4'h1, 64'h0,   64'h34, 1'b0, 64'h33,  64'h33,  1'b0, 1'b0);
    mw(4'h0, 1'b0, 64'h0, 4'h9, 64'h50);
    step("wmiss", 4'h1, 64'h0,   64'h51, 1'b0, 64'h50,  64'h34,  1'b0, 1'b1);
    step("rempt", 4'h9, 64'h0,   64'h52, 1'b0, 64'h51,  64'h51,  1'b0, 1'b0);
    step("estal", 4'h1, 64'h0,   64'h53, 1'b1, 64'h52,  64'h52,  1'b1, 1'b0);
    mw(4'h0, 1'b0, 64'h0, 4'h9, 64'h90);
    step("winv",  4'h1, 64'h0,   64'h91, 1'b0, 64'h90,  64'h52,  1'b0, 1'b0);
    prev = 64'h91;
    for (int k = 1; k <= 9; k++) begin
      step("ovcall", 4'h8, 64'hA00 + 64'(k), 64'h1000 + 64'(k), 1'b0, prev, prev, 1'b0, 1'b0);
      prev = 64'hA00 + 64'(k);
    end
    for (int j = 0; j < 8; j++) begin
      step("ovret", 4'h9, 64'h0, 64'h2000, 1'b0, prev, prev, 1'b0, 1'b0);
      prev = 64'h1000 + 64'(9 - j);
      mw(4'h0, 1'b0, 64'h0, 4'h9, prev);
      step("ovwret", 4'h1, 64'h0, 64'h3000 + 64'(j), 1'b0, prev, prev, 1'b0, 1'b0);
      prev = 64'h3000 + 64'(j);
    end
    step("ovlost", 4'h9, 64'h0, 64'h3008, 1'b0, 64'h3007, 64'h3007, 1'b0, 1'b0);
    step("ovstal", 4'h1, 64'h0, 64'h3009, 1'b1, 64'h3008, 64'h3008, 1'b1, 1'b0);
    mw(4'h0, 1'b0, 64'h0, 4'h9, 64'h400);
    step("ovinv",  4'h1, 64'h0, 64'h401, 1'b0, 64'h400, 64'h3008, 1'b0, 1'b0);
    step("fcall1", 4'h8, 64'h410, 64'h402, 1'b0, 64'h401, 64'h401, 1'b0, 1'b0);
    step("fcall2", 4'h8, 64'h420, 64'h411, 1'b0, 64'h410, 64'h410, 1'b0, 1'b0);
    mw(4'h7, 1'b0, 64'h600, 4'h0, 64'h0);
    step("fmisp",  4'h1, 64'h0,   64'h601, 1'b0, 64'h600, 64'h420, 1'b0, 1'b0);
    step("fret",   4'h9, 64'h0,   64'h602, 1'b0, 64'h601, 64'h601, 1'b0, 1'b0);
    step("fstal",  4'h1, 64'h0,   64'h603, 1'b1, 64'h602, 64'h602, 1'b1, 1'b0);
    mw(4'h0, 1'b0, 64'h0, 4'h9, 64'h700);
    step("fwret",  4'h1, 64'h0,   64'h701, 1'b0, 64'h700, 64'h602, 1'b0, 1'b0);
    prev = 64'h701;
    for (int k = 1; k <= 4; k++) begin
      step("qcall", 4'h8, 64'hC00 + 64'(k), 64'hB00 + 64'(k), 1'b0, prev, prev, 1'b0, 1'b0);
      prev = 64'hC00 + 64'(k);
    end
    for (int j = 0; j < 4; j++) begin
      step("qret", 4'h9, 64'h0, 64'hD00 + 64'(j), 1'b0, prev, prev, 1'b0, 1'b0);
      prev = 64'hB04 - 64'(j);
    end
    step("qfull", 4'h9, 64'h0, 64'hD09, 1'b0, 64'hB01, 64'hB01, 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) begin
      mw(4'h0, 1'b0, 64'h0, 4'h9, 64'hB04 - 64'(j));
      prev = (j == 0) ? 64'hB01 : 64'hB01 + 64'(j);
      step("qdrain", 4'h1, 64'h0, 64'hB02 + 64'(j), 1'b0, prev, prev, 1'b0, 1'b0);
    end
`else
    step("dret1", 4'h9, 64'h0, 64'h82, 1'b0, 64'h81, 64'h81, 1'b0, 1'b0);
    step("dret2", 4'h9, 64'h0, 64'h83, 1'b0, 64'h82, 64'h82, 1'b1, 1'b0);
    mw(4'h0, 1'b0, 64'h0, 4'h9, 64'h90);
    step("dw1",   4'h1, 64'h0, 64'h91, 1'b0, 64'h90, 64'h83, 1'b1, 1'b0);
    mw(4'h0, 1'b0, 64'h0, 4'h9, 64'h95);
    step("dw2",   4'h1, 64'h0, 64'h96, 1'b0, 64'h95, 64'h91, 1'b0, 1'b0);
    step("dseq",  4'h1, 64'h0, 64'h97, 1'b0, 64'h96, 64'h96, 1'b0, 1'b0);
`endif
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_select.md
# pc_select

Fetch-side PC control for the Y86-64 pipeline, directly upstream of `fetch`.
- Holds the F pipeline register (`F_predPC`) and predicts the next PC.
- Selects the PC driven into `fetch` each cycle: reset value, mispredicted-branch recovery, `ret` resolution, or prediction.
- Optionally predicts `ret` targets with a return-address stack (RAS), so the hazard unit does not stall on every `ret`.

## Interface
Parameters:
- `RAS_DEPTH`, 8: return-address stack entries (power of two).
- `RQ_DEPTH`, 4: outstanding-ret queue entries (power of two).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `f_icode`  in  4  icode of the instruction fetched at `f_pc` (from `fetch`).
- `f_valC`  in  64  constant word of that instruction.
- `f_valP`  in  64  fall-through address of that instruction.
- `F_stall`  in  1  hazard-unit stall; holds all state.
- `M_icode`  in  4  icode in the M stage.
- `M_Cnd`  in  1  branch condition in the M stage.
- `M_valA`  in  64  fall-through address of the jump in M.
- `W_icode`  in  4  icode in the W stage.
- `W_valM`  in  64  return address loaded by the `ret` in W.
- `f_pc`  out  64  PC presented to `fetch`.
- `F_predPC`  out  64  predicted PC register.
- `ret_stall`  out  1  hazard unit must stall F and bubble D.
- `ras_mispred`  out  1  a RAS-predicted `ret` resolved to a different target this cycle.

## Operation
Definitions:
- `mispred` = (`M_icode`==7) && !`M_Cnd`.
- `wret` = (`W_icode`==9).

`f_pc` priority, combinational:
1. `mispred`: `M_valA`.
2. `wret` and the ret needs redirect: `W_valM`. Without RAS, every `wret` redirects. With RAS, a `wret` redirects only if its queue entry had no prediction, or its predicted target != `W_valM`.
3. Otherwise: `F_predPC`.

`F_predPC` next value, loaded when `F_stall`=0:
- `f_icode` 7 or 8: `f_valC`.
- `f_icode` 9 with a RAS prediction: popped RAS top.
- Otherwise: `f_valP`.

Without RAS, `ret_stall`=1 while any `ret` is in F, D, E or M. The block tracks this with a 3-bit in-flight count: incremented on a fetched `ret` when `F_stall`=0, decremented on `wret`.

With RAS:
- **Call fetched** (`f_icode`==8, `F_stall`=0): push `f_valP`. When the stack is full, the oldest entry is overwritten; the stack is circular and the count saturates at `RAS_DEPTH`.
- **Ret fetched** (`f_icode`==9, `F_stall`=0):
  - RAS non-empty: pop; enqueue {valid=1, target} in the ret queue.
  - RAS empty: enqueue {valid=0}; `ret_stall`=1 until that entry retires.
- **Ret queue full at a ret fetch**: `ret_stall`=1; RAS and queue unchanged. The fetch is re-evaluated in the next unstalled cycle.
- **`wret`**: dequeue the head entry.
  - Valid entry whose target == `W_valM`: no redirect.
  - Valid entry whose target differs: `ras_mispred`=1, redirect to `W_valM`, and flush the RAS and the queue.
  - Invalid entry: redirect, no `ras_mispred`.
- **`mispred`**: in the same edge, first process any `wret` dequeue, then clear the queue and the RAS. Wrong-path pushes and pops are discarded.
- **Enqueue and dequeue in the same cycle**: both occur; occupancy is unchanged.
- **`wret` with an empty queue**: redirect to `W_valM`; no state change.

## Timing
- `f_pc` is combinational from the inputs; zero latency.
- `F_predPC`, the RAS, the queue and the in-flight count update on the rising edge of `clk`.
- `ret_stall` and `ras_mispred` are combinational from current state and inputs.
- Reset (asynchronous, any time, including mid-call or mid-ret):
  - `F_predPC`=0, RAS and queue empty, in-flight count 0.
  - Therefore `f_pc`=0, `ret_stall`=0, `ras_mispred`=0.
- `F_stall`=1 freezes all state, including pushes and pops. Redirects on `f_pc` still take effect.
- A redirect is one cycle: `F_predPC` captures the fall-through or target of the redirected instruction on the following edge.

## Configuration
- `PC_SELECT_RAS_EN` defined: RAS and ret queue built in; `ret` is predicted; `ret_stall` is asserted only on empty RAS or full queue.
- `PC_SELECT_RAS_EN` undefined: no RAS; `ras_mispred` tied to 0; `ret_stall` follows the in-flight count (classic PIPE behaviour).

## Test plan
- **Reset then sequential fetch:** release `rst`; `f_icode`=6, `f_valP`=2 -> `f_pc`=0; after the edge, `F_predPC`=2 and `f_pc`=2.
- **Jump predicted taken, then mispredicted:** `f_icode`=7, `f_valC`=0x40 -> `F_predPC`=0x40. Later `M_icode`=7, `M_Cnd`=0, `M_valA`=0x15 -> `f_pc`=0x15 that cycle.
- **RAS hit:** call with `f_valP`=0x30, then ret -> `F_predPC`=0x30, `ret_stall`=0. Later `wret` with `W_valM`=0x30 -> `f_pc`=`F_predPC`, `ras_mispred`=0.
- **RAS miss:** as above but `W_valM`=0x50 -> `ras_mispred`=1, `f_pc`=0x50; the next ret fetch sees an empty RAS and `ret_stall`=1.
- **Overflow and flush:** 9 calls with depth 8, then 8 rets -> predictions return in LIFO order, the oldest call being lost. `mispred` mid-sequence -> RAS empty afterwards.
- **Without the macro:** ret fetched -> `ret_stall`=1 for 3 cycles, until `W_icode`=9 with `W_valM`=0x22 -> `f_pc`=0x22, then `ret_stall`=0.
